// File: rtl/redun_mont_sq_iter.sv
// ---------------------------------------------------------------------------
// redun_mont_sq_iter
//   Iterated Montgomery squarer for the VDF datapath. One job squares the
//   operand x N times, each squaring followed by a Montgomery reduction:
//       y = x^(2^N) * R^-(2^N-1) mod P,   R = 2^(NUM_WRDS*WRD_BITS)
//   Operands are in redundant form: NUM_WRDS words of WRD_BITS+1 bits, and
//   word i has weight 2^(i*WRD_BITS). The squarer is sequenced as
//   SQ -> RLO -> RHI per iteration, and each phase lasts MULT_CYCLES cycles.
//
//   Optional feature macro: REDUN_MONT_INT_OUT_EN
//     When it is defined, o_int_dat/o_int_val report every intermediate
//     iteration result. When it is undefined, both outputs are tied to zero.
//
// Ports
//   i_clk, i_rst_n     clock and synchronous active-low reset
//   i_dat              operand x (redundant, value < 2P)
//   i_mod, i_mfac      modulus P and -P^-1 mod R (normalised)
//   i_iter             number of squarings N
//   i_val / o_rdy      job handshake (accepted only in IDLE)
//   i_abort            abandon the running job
//   o_dat / o_val      result and its valid flag; o_dat is held until i_rdy
//   i_rdy              result consumed
//   o_iter_cnt         squarings completed in the current job
//   o_int_dat/o_int_val  per-iteration result strobe (optional feature)
// ---------------------------------------------------------------------------
module redun_mont_sq_iter #(
    parameter int WRD_BITS    = 16,
    parameter int NUM_WRDS    = 64,
    parameter int SPEC_CARRY  = 2,
    parameter int MULT_CYCLES = 2,
    parameter int ITER_BITS   = 32
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]     i_dat,
    input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]     i_mod,
    input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]     i_mfac,
    input  logic [ITER_BITS-1:0]                 i_iter,
    input  logic                                 i_val,
    output logic                                 o_rdy,
    input  logic                                 i_abort,
    output logic [NUM_WRDS*(WRD_BITS+1)-1:0]     o_dat,
    output logic                                 o_val,
    input  logic                                 i_rdy,
    output logic [ITER_BITS-1:0]                 o_iter_cnt,
    output logic [NUM_WRDS*(WRD_BITS+1)-1:0]     o_int_dat,
    output logic                                 o_int_val
);
    localparam int W   = WRD_BITS;
    localparam int NW  = NUM_WRDS;
    localparam int SW  = W + 1;              // stored word width
    localparam int DW  = NW * SW;            // redundant operand width
    localparam int RW  = NW * W;             // log2(R)
    localparam int VW  = RW + 2;             // integer value of a redundant operand
    // The product register gets SPEC_CARRY extra words of headroom for carries.
    localparam int LW  = (2 * NW + ((SPEC_CARRY > 0) ? SPEC_CARRY : 1)) * W;
    localparam int YW  = RW + 4;             // reduced result before final subtraction
    localparam int NR  = 4;                  // (t + mP)/R < 5P, so four subtractions reach [0,P)
    localparam int PCW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SQ, RLO, RHI, DONE} state_t;

    state_t             state_reg, state_next;
    logic [PCW-1:0]     phase_reg;
    logic [VW-1:0]      a_reg;
    logic [RW-1:0]      mod_reg;
    logic [RW-1:0]      mfac_reg;
    logic [ITER_BITS-1:0] iter_reg;
    logic [ITER_BITS-1:0] cnt_reg;
    logic [LW-1:0]      t_reg;
    logic [RW-1:0]      m_reg;
    logic [DW-1:0]      dat_reg;
    logic               val_reg;

    logic               phase_last;
    logic               last_iter;
    logic               abort_req;
    logic               busy;

    // Collapse a redundant operand into its integer value.
    function automatic logic [VW-1:0] to_val(input logic [DW-1:0] d);
        logic [VW-1:0] acc;
        acc = '0;
        for (int i = 0; i < NW; i++) begin
            acc = acc + (VW'(d[i*SW +: SW]) << (i * W));
        end
        return acc;
    endfunction

    assign phase_last = (phase_reg == PCW'(MULT_CYCLES - 1));
    assign last_iter  = ((cnt_reg + ITER_BITS'(1)) == iter_reg);
    assign abort_req  = i_abort && (state_reg != IDLE);
    assign busy       = (state_reg == SQ) || (state_reg == RLO) || (state_reg == RHI);

    // ------------------------------------------------------------------
    // Multiplier datapath: operands are held stable in registers for the
    // whole phase, and the phase result is captured on its last cycle.
    // ------------------------------------------------------------------
    logic [LW-1:0] sq_full;
    logic [RW-1:0] m_prod;
    logic [LW-1:0] mp_sum;
    logic [YW-1:0] red_stage [NR+1];
    logic [RW-1:0] y_red;
    logic [DW-1:0] y_red_dat;

    assign sq_full = LW'(a_reg) * LW'(a_reg);
    // Only the low half of the square (mod R) enters the quotient digit m.
    assign m_prod  = RW'(t_reg[RW-1:0] * mfac_reg);
    // t + m*P is an exact multiple of R; the quotient is the upper half.
    assign mp_sum  = t_reg + LW'(m_reg) * LW'(mod_reg);
    assign red_stage[0] = YW'(mp_sum >> RW);

    genvar gi;
    generate
        for (gi = 0; gi < NR; gi++) begin : g_red
            assign red_stage[gi+1] = (red_stage[gi] >= YW'(mod_reg)) ?
                                     (red_stage[gi] - YW'(mod_reg)) : red_stage[gi];
        end
    endgenerate

    assign y_red = RW'(red_stage[NR]);

    generate
        for (gi = 0; gi < NW; gi++) begin : g_pack
            assign y_red_dat[gi*SW +: SW] = {1'b0, y_red[gi*W +: W]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        o_rdy      = 1'b0;
        case (state_reg)
            IDLE: begin
                o_rdy = 1'b1;
                if (i_val) begin
                    state_next = (i_iter == '0) ? DONE : SQ;
                end
            end
            SQ:   if (phase_last) state_next = RLO;
            RLO:  if (phase_last) state_next = RHI;
            RHI:  if (phase_last) state_next = last_iter ? DONE : SQ;
            DONE: if (i_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_req) begin
            state_next = IDLE;
        end
    end

`ifdef REDUN_MONT_INT_OUT_EN
    logic [DW-1:0] int_dat_reg;
    logic          int_val_reg;
    assign o_int_dat = int_dat_reg;
    assign o_int_val = int_val_reg;
`else
    assign o_int_dat = '0;
    assign o_int_val = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            phase_reg <= '0;
            a_reg     <= '0;
            mod_reg   <= '0;
            mfac_reg  <= '0;
            iter_reg  <= '0;
            cnt_reg   <= '0;
            t_reg     <= '0;
            m_reg     <= '0;
            dat_reg   <= '0;
            val_reg   <= 1'b0;
`ifdef REDUN_MONT_INT_OUT_EN
            int_dat_reg <= '0;
            int_val_reg <= 1'b0;
`endif
        end else begin
`ifdef REDUN_MONT_INT_OUT_EN
            int_val_reg <= 1'b0;
`endif
            phase_reg <= (busy && (state_next == state_reg)) ? phase_reg + PCW'(1) : '0;
            if (abort_req) begin
                // Counter and data registers keep their last values.
                val_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: if (i_val) begin
                        a_reg    <= to_val(i_dat);
                        mod_reg  <= RW'(to_val(i_mod));
                        mfac_reg <= RW'(to_val(i_mfac));
                        iter_reg <= i_iter;
                        cnt_reg  <= '0;
                        if (i_iter == '0) begin
                            dat_reg <= i_dat;
                            val_reg <= 1'b1;
                        end
                    end
                    SQ:  if (phase_last) t_reg <= sq_full;
                    RLO: if (phase_last) m_reg <= m_prod;
                    RHI: if (phase_last) begin
                        a_reg   <= VW'(y_red);
                        cnt_reg <= cnt_reg + ITER_BITS'(1);
                        if (last_iter) begin
                            dat_reg <= y_red_dat;
                            val_reg <= 1'b1;
                        end else begin
`ifdef REDUN_MONT_INT_OUT_EN
                            int_dat_reg <= y_red_dat;
                            int_val_reg <= 1'b1;
`endif
                        end
                    end
                    DONE: if (i_rdy) val_reg <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign o_dat      = dat_reg;
    assign o_val      = val_reg;
    assign o_iter_cnt = cnt_reg;

endmodule
